// File: rtl/mem_stage_pkg.sv
// Shared encodings and lane helpers for the MIPS memory-access stage.
// Used by mem_stage_unit and its interface/sub-modules.
package mem_stage_pkg;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LW   = 4'd1;
  localparam logic [3:0] OP_LH   = 4'd2;
  localparam logic [3:0] OP_LHU  = 4'd3;
  localparam logic [3:0] OP_LB   = 4'd4;
  localparam logic [3:0] OP_LBU  = 4'd5;
  localparam logic [3:0] OP_SW   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SB   = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic is_word(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic is_half(input logic [3:0] op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  function automatic logic [3:0] byte_en(input logic [3:0] op, input logic [1:0] a);
    logic [3:0] be;
    case (op)
      OP_SW:   be = 4'b1111;
      OP_SH:   be = a[1] ? 4'b1100 : 4'b0011;
      OP_SB:   be = 4'b0001 << a;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate narrow store data so every enabled lane sees the right bytes.
  function automatic logic [31:0] store_lanes(input logic [3:0] op, input logic [31:0] d);
    logic [31:0] r;
    case (op)
      OP_SH:   r = {2{d[15:0]}};
      OP_SB:   r = {4{d[7:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_ext(input logic [3:0] op, input logic [31:0] w,
                                           input logic [1:0] a);
    logic [31:0] sh;
    logic [31:0] r;
    sh = w >> {a, 3'b000};
    case (op)
      OP_LW:   r = w;
      OP_LH:   r = {{16{sh[15]}}, sh[15:0]};
      OP_LHU:  r = {16'h0000, sh[15:0]};
      OP_LB:   r = {{24{sh[7]}}, sh[7:0]};
      OP_LBU:  r = {24'h000000, sh[7:0]};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_unit_if.sv
// M-stage to memory-stage bus; exc_w exists only when MISALIGN_EXC_EN is defined.
// master = pipeline side, slave = mem_stage_unit.
interface mem_stage_unit_if #(
  parameter int FWD_N = 3
);
  localparam int SEL_W = $clog2(FWD_N + 1);

  logic                 valid_in;
  logic [3:0]           mem_op;
  logic [31:0]          addr;
  logic [31:0]          rt_data;
  logic [FWD_N*32-1:0]  fwd_data;
  logic [SEL_W-1:0]     fwd_sel;
  logic [31:0]          pc;
  logic                 stall;
  logic                 valid_w;
  logic [31:0]          rdata_w;
  logic [31:0]          pc_w;
`ifdef MISALIGN_EXC_EN
  logic                 exc_w;
`endif

  modport master (
    output valid_in, mem_op, addr, rt_data, fwd_data, fwd_sel, pc,
    input  stall, valid_w, rdata_w,
`ifdef MISALIGN_EXC_EN
    input  exc_w,
`endif
    input  pc_w
  );

  modport slave (
    input  valid_in, mem_op, addr, rt_data, fwd_data, fwd_sel, pc,
    output stall, valid_w, rdata_w,
`ifdef MISALIGN_EXC_EN
    output exc_w,
`endif
    output pc_w
  );

endinterface

// File: rtl/mem_stage_unit_dm_bank.sv
// Data memory bank: byte-enable synchronous write, asynchronous read,
// whole array cleared by the active-low asynchronous reset.
module dm_bank #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] idx,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/mem_stage_unit.sv
// Multi-cycle MIPS memory stage: store forwarding mux, access FSM, M/W registers.
// MISALIGN_EXC_EN: misaligned word/half accesses raise exc_w instead of being aligned.
//
// state | meaning
// IDLE  | no access in progress; non-memory ops pass to W in one cycle
// BUSY  | access in progress, cnt counts down to the commit edge
// DONE  | access complete, W registers load the result
module mem_stage_unit
  import mem_stage_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int FWD_N       = 3,
  parameter int LAT         = 2
) (
  input logic             clk,
  input logic             reset,
  mem_stage_unit_if.slave bus
);

  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int CW    = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int SEL_W = $clog2(FWD_N + 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    op_q;
  logic [31:0]   addr_q, wdata_q, ldata_q;
  logic [31:0]   sdata, addr_al, bank_rdata;
  logic [3:0]    bank_be;
  logic          is_mem, start;
  logic          valid_w_q;
  logic [31:0]   rdata_w_q, pc_w_q;

  always_comb begin
    sdata = bus.rt_data;
    for (int k = 1; k <= FWD_N; k++)
      if (bus.fwd_sel == SEL_W'(k)) sdata = bus.fwd_data[32*(k-1) +: 32];
  end

  always_comb begin
    addr_al = bus.addr;
    if (is_word(bus.mem_op))      addr_al[1:0] = 2'b00;
    else if (is_half(bus.mem_op)) addr_al[0]   = 1'b0;
  end

  assign is_mem = is_load(bus.mem_op) || is_store(bus.mem_op);

`ifdef MISALIGN_EXC_EN
  logic misalign, exc_w_q;
  assign misalign = (is_word(bus.mem_op) && (bus.addr[1:0] != 2'b00)) ||
                    (is_half(bus.mem_op) && bus.addr[0]);
  assign start    = bus.valid_in && is_mem && !misalign;
  assign bus.exc_w = exc_w_q;
`else
  assign start    = bus.valid_in && is_mem;
`endif

  // Gated by reset so stall falls the moment reset asserts, even with valid_in held.
  assign bus.stall = reset && (((state == ST_IDLE) && start) || (state == ST_BUSY));

  assign bank_be = ((state == ST_BUSY) && (cnt == '0) && is_store(op_q))
                   ? byte_en(op_q, addr_q[1:0]) : 4'b0000;

  dm_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank (
    .clk   (clk),
    .reset (reset),
    .idx   (addr_q[AW+1:2]),
    .be    (bank_be),
    .wdata (wdata_q),
    .rdata (bank_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      op_q      <= OP_NONE;
      addr_q    <= '0;
      wdata_q   <= '0;
      ldata_q   <= '0;
      valid_w_q <= 1'b0;
      rdata_w_q <= '0;
      pc_w_q    <= '0;
`ifdef MISALIGN_EXC_EN
      exc_w_q   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_BUSY;
            cnt       <= CW'(LAT - 1);
            op_q      <= bus.mem_op;
            addr_q    <= addr_al;
            wdata_q   <= store_lanes(bus.mem_op, sdata);
            valid_w_q <= 1'b0;
            rdata_w_q <= '0;
`ifdef MISALIGN_EXC_EN
            exc_w_q   <= 1'b0;
`endif
          end else begin
            valid_w_q <= bus.valid_in;
            rdata_w_q <= '0;
            pc_w_q    <= bus.pc;
`ifdef MISALIGN_EXC_EN
            exc_w_q   <= bus.valid_in && is_mem && misalign;
`endif
          end
        end
        ST_BUSY: begin
          valid_w_q <= 1'b0;
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            ldata_q <= is_load(op_q) ? load_ext(op_q, bank_rdata, addr_q[1:0]) : '0;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          valid_w_q <= 1'b1;
          rdata_w_q <= ldata_q;
          pc_w_q    <= bus.pc;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.valid_w = valid_w_q;
  assign bus.rdata_w = rdata_w_q;
  assign bus.pc_w    = pc_w_q;

endmodule

// File: tb/tb_mem_stage_unit.sv
// Scoreboard bench for mem_stage_unit: LAT=2 and LAT=4 instances checked
// against a byte-level memory model (MISALIGN_EXC_EN aware).
module tb_mem_stage_unit;

  localparam logic [31:0] SLOT0 = 32'h1111_1111;
  localparam logic [31:0] SLOT1 = 32'hCAFE_F00D;
  localparam logic [31:0] SLOT2 = 32'h3333_3333;

  typedef struct {
    logic [31:0] rd;
    logic [31:0] pc;
    logic        exc;
  } exp_t;

  logic clk = 1'b0;
  logic rst2, rst4;
  int   total = 0;
  int   bad   = 0;
  int   pc_ctr = 32'h400;
  exp_t exp_q[$];
  logic [7:0] mdl [2][1024];

  always #5 clk = ~clk;

  mem_stage_unit_if #(.FWD_N(3)) if2();
  mem_stage_unit_if #(.FWD_N(3)) if4();

  mem_stage_unit #(.DEPTH_WORDS(256), .FWD_N(3), .LAT(2)) dut2 (
    .clk(clk), .reset(rst2), .bus(if2.slave));
  mem_stage_unit #(.DEPTH_WORDS(256), .FWD_N(3), .LAT(4)) dut4 (
    .clk(clk), .reset(rst4), .bus(if4.slave));

  function automatic logic get_stall(input bit u);
    return u ? if4.stall : if2.stall;
  endfunction
  function automatic logic get_valid(input bit u);
    return u ? if4.valid_w : if2.valid_w;
  endfunction
  function automatic logic [31:0] get_rdata(input bit u);
    return u ? if4.rdata_w : if2.rdata_w;
  endfunction
  function automatic logic [31:0] get_pc(input bit u);
    return u ? if4.pc_w : if2.pc_w;
  endfunction
`ifdef MISALIGN_EXC_EN
  function automatic logic get_exc(input bit u);
    return u ? if4.exc_w : if2.exc_w;
  endfunction
`endif

  task automatic drv(input bit u, input logic v, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] rt, input logic [1:0] sel, input logic [31:0] p);
    if (u) begin
      if4.valid_in = v; if4.mem_op = op; if4.addr = a;
      if4.rt_data = rt; if4.fwd_sel = sel; if4.pc = p;
    end else begin
      if2.valid_in = v; if2.mem_op = op; if2.addr = a;
      if2.rt_data = rt; if2.fwd_sel = sel; if2.pc = p;
    end
  endtask

  function automatic bit mdl_misaligned(input logic [3:0] op, input logic [31:0] a);
`ifdef MISALIGN_EXC_EN
    if ((op == 4'd1 || op == 4'd6) && a[1:0] != 2'b00) return 1'b1;
    if ((op == 4'd2 || op == 4'd3 || op == 4'd7) && a[0]) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] mdl_load(input int u, input logic [3:0] op, input logic [31:0] a);
    int ba;
    ba = int'(a & 32'h3FF);
    case (op)
      4'd1: begin
        ba = ba & ~3;
        return {mdl[u][ba+3], mdl[u][ba+2], mdl[u][ba+1], mdl[u][ba]};
      end
      4'd2: begin
        ba = ba & ~1;
        return {{16{mdl[u][ba+1][7]}}, mdl[u][ba+1], mdl[u][ba]};
      end
      4'd3: begin
        ba = ba & ~1;
        return {16'h0000, mdl[u][ba+1], mdl[u][ba]};
      end
      4'd4: return {{24{mdl[u][ba][7]}}, mdl[u][ba]};
      4'd5: return {24'h000000, mdl[u][ba]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic mdl_store(input int u, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] d);
    int ba;
    ba = int'(a & 32'h3FF);
    if (op == 4'd6) begin
      ba = ba & ~3;
      for (int i = 0; i < 4; i++) mdl[u][ba+i] = d[8*i +: 8];
    end else if (op == 4'd7) begin
      ba = ba & ~1;
      mdl[u][ba]   = d[7:0];
      mdl[u][ba+1] = d[15:8];
    end else if (op == 4'd8) begin
      mdl[u][ba] = d[7:0];
    end
  endtask

  task automatic mdl_clear(input int u);
    for (int i = 0; i < 1024; i++) mdl[u][i] = 8'h00;
  endtask

  // Called at posedge+1; returns at posedge+1 after W has loaded, bus left idle.
  task automatic run_op(input bit u, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] rt, input logic [1:0] sel, input string name);
    exp_t e;
    logic [31:0] sd;
    bit mem, mis, done;
    int n, es;
    pc_ctr += 4;
    drv(u, 1'b1, op, a, rt, sel, pc_ctr);
    mem = (op >= 4'd1) && (op <= 4'd8);
    mis = mem && mdl_misaligned(op, a);
    es  = (mem && !mis) ? (u ? 5 : 3) : 0;
    sd  = (sel == 2'd1) ? SLOT0 : (sel == 2'd2) ? SLOT1 : (sel == 2'd3) ? SLOT2 : rt;
    e.rd  = (op >= 4'd1 && op <= 4'd5 && !mis) ? mdl_load(u, op, a) : 32'h0;
    e.pc  = pc_ctr;
    e.exc = mis;
    if (!mis) mdl_store(u, op, a, sd);
    exp_q.push_back(e);
    n = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (get_stall(u)) begin
        if (n > 0) begin
          total++;
          if (get_valid(u) !== 1'b0) begin
            bad++;
            $display("FAIL %s valid_w_during_stall got=%b want=0", name, get_valid(u));
          end
        end
        n++;
      end else done = 1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s stall_timeout got=%0d cycles want=%0d", name, n, es);
    end else if (n !== es) begin
      bad++;
      $display("FAIL %s stall_cycles got=%0d want=%0d", name, n, es);
    end
    @(posedge clk); #1;
    e = exp_q.pop_front();
    total++;
    if (get_valid(u) !== 1'b1) begin
      bad++;
      $display("FAIL %s valid_w got=%b want=1", name, get_valid(u));
    end
    total++;
    if (get_rdata(u) !== e.rd) begin
      bad++;
      $display("FAIL %s rdata_w got=%h want=%h", name, get_rdata(u), e.rd);
    end
    total++;
    if (get_pc(u) !== e.pc) begin
      bad++;
      $display("FAIL %s pc_w got=%h want=%h", name, get_pc(u), e.pc);
    end
`ifdef MISALIGN_EXC_EN
    total++;
    if (get_exc(u) !== e.exc) begin
      bad++;
      $display("FAIL %s exc_w got=%b want=%b", name, get_exc(u), e.exc);
    end
`endif
    drv(u, 1'b0, 4'd0, 32'h0, 32'h0, 2'd0, 32'h0);
  endtask

  task automatic test_reset;
    for (int u = 0; u < 2; u++) begin
      total++;
      if (get_stall(u[0]) !== 1'b0 || get_valid(u[0]) !== 1'b0) begin
        bad++;
        $display("FAIL reset_ctrl dut%0d got stall=%b valid=%b want 0/0",
                 u, get_stall(u[0]), get_valid(u[0]));
      end
      total++;
      if (get_rdata(u[0]) !== 32'h0 || get_pc(u[0]) !== 32'h0) begin
        bad++;
        $display("FAIL reset_data dut%0d got rdata=%h pc=%h want 0/0",
                 u, get_rdata(u[0]), get_pc(u[0]));
      end
    end
  endtask

  task automatic test_word;
    run_op(0, 4'd6, 32'h10, 32'h1234_5678, 2'd0, "sw_10");
    run_op(0, 4'd1, 32'h10, 32'h0, 2'd0, "lw_10");
  endtask

  task automatic test_byte;
    run_op(0, 4'd8, 32'h13, 32'h0000_0080, 2'd0, "sb_13");
    run_op(0, 4'd4, 32'h13, 32'h0, 2'd0, "lb_13");
    run_op(0, 4'd5, 32'h13, 32'h0, 2'd0, "lbu_13");
    run_op(0, 4'd1, 32'h10, 32'h0, 2'd0, "lw_10_merged");
  endtask

  task automatic test_half;
    run_op(0, 4'd7, 32'h22, 32'h0000_BEEF, 2'd0, "sh_22");
    run_op(0, 4'd2, 32'h22, 32'h0, 2'd0, "lh_22");
    run_op(0, 4'd3, 32'h20, 32'h0, 2'd0, "lhu_20");
  endtask

  task automatic test_fwd;
    run_op(0, 4'd6, 32'h40, 32'h0, 2'd2, "sw_fwd_slot1");
    run_op(0, 4'd1, 32'h40, 32'h0, 2'd0, "lw_40");
    run_op(0, 4'd6, 32'h44, 32'h5555_AAAA, 2'd1, "sw_fwd_slot0");
    run_op(0, 4'd1, 32'h44, 32'h0, 2'd0, "lw_44");
  endtask

  task automatic test_misalign;
    run_op(0, 4'd1, 32'h41, 32'h0, 2'd0, "lw_41");
    run_op(0, 4'd2, 32'h23, 32'h0, 2'd0, "lh_23");
  endtask

  task automatic test_wrap_and_none;
    run_op(0, 4'd1, 32'h0000_0410, 32'h0, 2'd0, "lw_wrap");
    run_op(0, 4'd0, 32'h10, 32'hFFFF_FFFF, 2'd0, "none_op");
    run_op(0, 4'd12, 32'h10, 32'hFFFF_FFFF, 2'd0, "bad_op");
    @(posedge clk); #1;
    total++;
    if (if2.valid_w !== 1'b0) begin
      bad++;
      $display("FAIL idle_valid got=%b want=0", if2.valid_w);
    end
  endtask

  task automatic test_back_to_back;
    run_op(0, 4'd6, 32'h60, 32'hDEAD_BEEF, 2'd0, "b2b_sw");
    run_op(0, 4'd1, 32'h60, 32'h0, 2'd0, "b2b_lw");
    run_op(0, 4'd8, 32'h61, 32'h0, 2'd3, "b2b_sb_slot2");
    run_op(0, 4'd1, 32'h60, 32'h0, 2'd0, "b2b_lw2");
  endtask

  task automatic test_lat4;
    run_op(1, 4'd6, 32'h80, 32'h0BAD_F00D, 2'd0, "l4_sw");
    run_op(1, 4'd1, 32'h80, 32'h0, 2'd0, "l4_lw");
  endtask

  task automatic test_reset_mid_access;
    pc_ctr += 4;
    drv(1, 1'b1, 4'd6, 32'h40, 32'hAAAA_5555, 2'd0, pc_ctr);
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (if4.stall !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_busy_stall got=%b want=1", if4.stall);
    end
    rst4 = 1'b0;
    #1;
    total++;
    if (if4.stall !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_stall got=%b want=0", if4.stall);
    end
    @(negedge clk);
    drv(1, 1'b0, 4'd0, 32'h0, 32'h0, 2'd0, 32'h0);
    rst4 = 1'b1;
    mdl_clear(1);
    @(posedge clk); #1;
    run_op(1, 4'd1, 32'h40, 32'h0, 2'd0, "rst_lw_40");
  endtask

  initial begin
    rst2 = 1'b0; rst4 = 1'b0;
    mdl_clear(0); mdl_clear(1);
    if2.fwd_data = {SLOT2, SLOT1, SLOT0};
    if4.fwd_data = {SLOT2, SLOT1, SLOT0};
    drv(0, 1'b0, 4'd0, 32'h0, 32'h0, 2'd0, 32'h0);
    drv(1, 1'b0, 4'd0, 32'h0, 32'h0, 2'd0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    @(negedge clk);
    rst2 = 1'b1; rst4 = 1'b1;
    @(posedge clk); #1;
    test_word;
    test_byte;
    test_half;
    test_fwd;
    test_misalign;
    test_wrap_and_none;
    test_back_to_back;
    test_lat4;
    test_reset_mid_access;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
